// File: rtl/tm1638_display_pkg.sv
// Shared types and command constants for the TM1638 display writer.
package tm1638_display_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_BIT_LO,
        S_BIT_HI,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_CTRL       = 8'h80;

    localparam logic [1:0] TXN_DATA = 2'd0;
    localparam logic [1:0] TXN_RAM  = 2'd1;
    localparam logic [1:0] TXN_CTRL = 2'd2;

    localparam logic [4:0] RAM_LAST_BYTE = 5'd16;

    // Index of the final byte in a transaction: the RAM write carries the
    // address command plus sixteen data bytes, the others a single command.
    function automatic logic [4:0] lastByteOf(input logic [1:0] txn);
        return (txn == TXN_RAM) ? RAM_LAST_BYTE : 5'd0;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD to common-cathode 7-segment decoder, bit order gfedcba, codes 10-15 blank.
module seg7_decode (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pure lookup; anything outside 0-9 shows as a blank digit.
    always_comb begin
        o_seg = 7'h00;
        case (i_bcd)
            4'd0: o_seg = 7'h3F;
            4'd1: o_seg = 7'h06;
            4'd2: o_seg = 7'h5B;
            4'd3: o_seg = 7'h4F;
            4'd4: o_seg = 7'h66;
            4'd5: o_seg = 7'h6D;
            4'd6: o_seg = 7'h7D;
            4'd7: o_seg = 7'h07;
            4'd8: o_seg = 7'h7F;
            4'd9: o_seg = 7'h6F;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/tm1638_display.sv
// Periodic TM1638 frame writer: snapshots digits/dots/LEDs and shifts the
// data command, the full display RAM and the control command out LSB first.
module tm1638_display
    import tm1638_display_pkg::*;
#(
    parameter int DIV = 25
) (
    input  logic        clk,
    input  logic        rs,
    input  logic        en,
    input  logic [31:0] digits,
    input  logic [7:0]  dots,
    input  logic [7:0]  leds,
    input  logic [2:0]  brightness,
    input  logic        disp_on,
    output logic        tm_stb,
    output logic        tm_clk,
    output logic        tm_dio,
    output logic        busy,
    output logic        frame_done
);

    localparam int DIVW = $clog2(2 * DIV);
    localparam logic [DIVW-1:0] BIT_LAST = DIVW'(DIV - 1);
    localparam logic [DIVW-1:0] GAP_LAST = DIVW'(2 * DIV - 1);

    state_t          r_state;
    state_t          w_next;
    logic [DIVW-1:0] r_div;
    logic [2:0]      r_bit,  w_nextBit;
    logic [4:0]      r_byte, w_nextByte;
    logic [1:0]      r_txn,  w_nextTxn;
    logic            w_last;
    logic            w_snap;

    logic [31:0]     r_digits;
    logic [7:0]      r_dots;
    logic [7:0]      r_leds;
    logic [2:0]      r_bright;
    logic            r_dispOn;

    logic [3:0]      w_addr;
    logic [3:0]      w_digit;
    logic [6:0]      w_seg;
    logic [7:0]      w_byteVal;

    logic            r_stb, r_clk, r_dio, r_busy, r_frameDone;

    // Phase-end detect: the gap is twice as long as every other timed phase.
    always_comb begin
        w_last = (r_state == S_GAP) ? (r_div == GAP_LAST) : (r_div == BIT_LAST);
    end

    // Next state and next bit/byte/transaction position.
    always_comb begin
        w_next     = r_state;
        w_nextBit  = r_bit;
        w_nextByte = r_byte;
        w_nextTxn  = r_txn;
        w_snap     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_next     = S_SETUP;
                    w_nextTxn  = TXN_DATA;
                    w_nextByte = 5'd0;
                    w_nextBit  = 3'd0;
                    w_snap     = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_last) begin
                    w_next     = S_BIT_LO;
                    w_nextByte = 5'd0;
                    w_nextBit  = 3'd0;
                end
            end
            S_BIT_LO: begin
                if (w_last) begin
                    w_next = S_BIT_HI;
                end
            end
            S_BIT_HI: begin
                if (w_last) begin
                    if (r_bit != 3'd7) begin
                        w_next    = S_BIT_LO;
                        w_nextBit = 3'(r_bit + 3'd1);
                    end else if (r_byte != lastByteOf(r_txn)) begin
                        w_next     = S_BIT_LO;
                        w_nextBit  = 3'd0;
                        w_nextByte = 5'(r_byte + 5'd1);
                    end else begin
                        w_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (w_last) begin
                    if (r_txn == TXN_CTRL) begin
                        w_next = S_DONE;
                    end else begin
                        w_next    = S_SETUP;
                        w_nextTxn = 2'(r_txn + 2'd1);
                    end
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // RAM byte k (k >= 1) maps to address k-1; even addresses hold a digit, odd an LED.
    assign w_addr  = 4'(w_nextByte - 5'd1);
    assign w_digit = r_digits[{w_addr[3:1], 2'b00} +: 4];

    seg7_decode u_seg7 (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Value of the byte that the next bit position belongs to.
    always_comb begin
        w_byteVal = CMD_CTRL | {4'b0000, r_dispOn, r_bright};
        case (w_nextTxn)
            TXN_DATA: w_byteVal = CMD_DATA_WRITE;
            TXN_RAM: begin
                if (w_nextByte == 5'd0) begin
                    w_byteVal = CMD_ADDR0;
                end else if (w_addr[0]) begin
                    w_byteVal = {7'b0000000, r_leds[w_addr[3:1]]};
                end else begin
                    w_byteVal = {r_dots[w_addr[3:1]], w_seg};
                end
            end
            default: w_byteVal = CMD_CTRL | {4'b0000, r_dispOn, r_bright};
        endcase
    end

    // State, phase timer and position counters.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_txn   <= '0;
        end else begin
            r_state <= w_next;
            r_div   <= (w_next != r_state || r_state == S_IDLE) ? '0 : DIVW'(r_div + 1'b1);
            r_bit   <= w_nextBit;
            r_byte  <= w_nextByte;
            r_txn   <= w_nextTxn;
        end
    end

    // Input snapshot taken as a frame starts so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_digits <= '0;
            r_dots   <= '0;
            r_leds   <= '0;
            r_bright <= '0;
            r_dispOn <= 1'b0;
        end else if (w_snap) begin
            r_digits <= digits;
            r_dots   <= dots;
            r_leds   <= leds;
            r_bright <= brightness;
            r_dispOn <= disp_on;
        end
    end

    // Registered pin outputs derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rs) begin
            r_stb       <= 1'b1;
            r_clk       <= 1'b1;
            r_dio       <= 1'b1;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_stb       <= !(w_next inside {S_SETUP, S_BIT_LO, S_BIT_HI});
            r_clk       <= (w_next != S_BIT_LO);
            r_busy      <= (w_next inside {S_SETUP, S_BIT_LO, S_BIT_HI, S_GAP});
            r_frameDone <= (w_next == S_DONE);
            if (w_next == S_BIT_LO && r_state != S_BIT_LO) begin
                r_dio <= w_byteVal[w_nextBit];
            end
        end
    end

    assign tm_stb     = r_stb;
    assign tm_clk     = r_clk;
    assign tm_dio     = r_dio;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_tm1638_display.sv
// Directed bench for tm1638_display with DIV=2: decodes the serial stream
// back into bytes and checks frame timing and display RAM contents.
module tb_tm1638_display;

   logic        clk = 1'b0;
   logic        rs = 1'b1;
   logic        en = 1'b1;
   logic [31:0] digits = '0;
   logic [7:0]  dots = '0;
   logic [7:0]  leds = '0;
   logic [2:0]  brightness = '0;
   logic        disp_on = 1'b0;
   logic        tm_stb, tm_clk, tm_dio, busy, frame_done;

   int checks = 0;
   int errors = 0;

   logic       monClear = 1'b0;
   logic       prevClk = 1'b1;
   logic       prevStb = 1'b1;
   logic       prevDio = 1'b1;
   int         byteCount = 0;
   int         bitCnt = 0;
   int         stbFalls = 0;
   int         riseCount = 0;
   int         dioGlitches = 0;
   logic [7:0] shiftReg = '0;
   logic [7:0] capBytes [64];

   tm1638_display #(.DIV(2)) dut (
      .clk        (clk),
      .rs         (rs),
      .en         (en),
      .digits     (digits),
      .dots       (dots),
      .leds       (leds),
      .brightness (brightness),
      .disp_on    (disp_on),
      .tm_stb     (tm_stb),
      .tm_clk     (tm_clk),
      .tm_dio     (tm_dio),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Receiver model: shifts DIO in LSB first on each CLK rise while STB is low.
   always @(negedge clk) begin
      if (monClear) begin
         byteCount = 0;
         bitCnt = 0;
         stbFalls = 0;
         dioGlitches = 0;
      end else begin
         if (prevStb === 1'b1 && tm_stb === 1'b0) stbFalls++;
         if (tm_stb === 1'b0 && prevClk === 1'b1 && tm_clk === 1'b1 && tm_dio !== prevDio)
            dioGlitches++;
         if (tm_stb !== 1'b0) begin
            bitCnt = 0;
         end else if (prevClk === 1'b0 && tm_clk === 1'b1) begin
            shiftReg = {tm_dio, shiftReg[7:1]};
            bitCnt++;
            if (bitCnt == 8) begin
               if (byteCount < 64) capBytes[byteCount] = shiftReg;
               byteCount++;
               bitCnt = 0;
            end
         end
      end
      if (prevClk === 1'b0 && tm_clk === 1'b1) riseCount++;
      prevClk = tm_clk;
      prevStb = tm_stb;
      prevDio = tm_dio;
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic clearMonitor();
      @(negedge clk) monClear = 1'b1;
      @(negedge clk);
      @(negedge clk) monClear = 1'b0;
   endtask

   task automatic waitDone(inout int c);
      while (frame_done !== 1'b1 && c < 2000) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (tm_stb !== 1'b1) begin errors++; $display("[TB] FAIL reset_stb got=%b exp=1", tm_stb); end
      checks++; if (tm_clk !== 1'b1) begin errors++; $display("[TB] FAIL reset_clk got=%b exp=1", tm_clk); end
      checks++; if (tm_dio !== 1'b1) begin errors++; $display("[TB] FAIL reset_dio got=%b exp=1", tm_dio); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", frame_done); end
      checks++; if (riseCount !== 0) begin errors++; $display("[TB] FAIL reset_clk_edges got=%0d exp=0", riseCount); end
      en = 1'b0;
      @(negedge clk) rs = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
      checks++; if (tm_stb !== 1'b1) begin errors++; $display("[TB] FAIL idle_stb got=%b exp=1", tm_stb); end
   endtask

   task automatic test_basic_frame();
      int c;
      digits = '0; dots = '0; leds = '0; brightness = '0; disp_on = 1'b0;
      clearMonitor();
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
      c = 1;
      checks++; if (tm_stb !== 1'b0) begin errors++; $display("[TB] FAIL start_stb got=%b exp=0", tm_stb); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy got=%b exp=1", busy); end
      waitDone(c);
      checks++; if (c !== 627 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL frame_latency got=%0d exp=627", c); end
      @(negedge clk);
      checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse_width got=%b exp=0", frame_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL after_done_busy got=%b exp=0", busy); end
      checks++; if (stbFalls !== 3) begin errors++; $display("[TB] FAIL stb_transactions got=%0d exp=3", stbFalls); end
      checks++; if (byteCount !== 19) begin errors++; $display("[TB] FAIL byte_count got=%0d exp=19", byteCount); end
      checks++; if (capBytes[0] !== 8'h40) begin errors++; $display("[TB] FAIL first_8_bits got=%h exp=40", capBytes[0]); end
      checks++; if (capBytes[1] !== 8'hC0) begin errors++; $display("[TB] FAIL addr_cmd got=%h exp=c0", capBytes[1]); end
      checks++; if (dioGlitches !== 0) begin errors++; $display("[TB] FAIL dio_stable_clk_high got=%0d exp=0", dioGlitches); end
   endtask

   task automatic test_digits();
      int c;
      int pos [9] = '{2, 4, 6, 16, 3, 17, 5, 18, 1};
      logic [7:0] expv [9] = '{8'h6F, 8'hED, 8'h3F, 8'h3F, 8'h01, 8'h01, 8'h00, 8'h80, 8'hC0};
      digits = 32'h0000_0059; dots = 8'h02; leds = 8'h81; brightness = '0; disp_on = 1'b0;
      clearMonitor();
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
      c = 1;
      waitDone(c);
      checks++; if (c !== 627 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL digits_latency got=%0d exp=627", c); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (capBytes[pos[i]] !== expv[i]) begin
            errors++;
            $display("[TB] FAIL digits_byte%0d got=%h exp=%h", pos[i], capBytes[pos[i]], expv[i]);
         end
      end
   endtask

   task automatic test_out_of_range();
      int c;
      int pos [9] = '{2, 4, 6, 8, 10, 12, 14, 16, 18};
      logic [7:0] expv [9] = '{8'h06, 8'h5B, 8'h4F, 8'h00, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h8B};
      digits = 32'h8765_A321; dots = '0; leds = '0; brightness = 3'd3; disp_on = 1'b1;
      clearMonitor();
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
      c = 1;
      waitDone(c);
      checks++; if (byteCount !== 19) begin errors++; $display("[TB] FAIL oor_byte_count got=%0d exp=19", byteCount); end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (capBytes[pos[i]] !== expv[i]) begin
            errors++;
            $display("[TB] FAIL oor_byte%0d got=%h exp=%h", pos[i], capBytes[pos[i]], expv[i]);
         end
      end
   endtask

   task automatic test_snapshot_refresh();
      int c;
      digits = 32'h1111_1111; dots = '0; leds = '0; brightness = '0; disp_on = 1'b0;
      clearMonitor();
      @(negedge clk) en = 1'b1;
      @(negedge clk);
      c = 1;
      while (frame_done !== 1'b1 && c < 2000) begin
         @(negedge clk);
         c++;
         if (c == 200) digits = 32'h2222_2222;
      end
      checks++; if (c !== 627 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL refresh_latency got=%0d exp=627", c); end
      @(negedge clk);
      checks++; if (tm_stb !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL refresh_idle_cycle got=%b%b exp=10", tm_stb, busy); end
      @(negedge clk) en = 1'b0;
      checks++; if (tm_stb !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL refresh_restart got=%b%b exp=01", tm_stb, busy); end
      c = 1;
      waitDone(c);
      checks++; if (c !== 627 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL refresh_second_latency got=%0d exp=627", c); end
      checks++; if (byteCount !== 38) begin errors++; $display("[TB] FAIL refresh_byte_count got=%0d exp=38", byteCount); end
      checks++; if (capBytes[2] !== 8'h06) begin errors++; $display("[TB] FAIL refresh_old_digit got=%h exp=06", capBytes[2]); end
      checks++; if (capBytes[19] !== 8'h40) begin errors++; $display("[TB] FAIL refresh_second_cmd got=%h exp=40", capBytes[19]); end
      checks++; if (capBytes[21] !== 8'h5B) begin errors++; $display("[TB] FAIL refresh_new_digit got=%h exp=5b", capBytes[21]); end
   endtask

   task automatic test_reset_mid_frame();
      int c;
      int r;
      digits = 32'h0000_0000; dots = '0; leds = '0; brightness = '0; disp_on = 1'b0;
      clearMonitor();
      @(negedge clk) en = 1'b1;
      @(negedge clk) en = 1'b0;
      c = 1;
      while (byteCount < 6 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      checks++; if (byteCount !== 6) begin errors++; $display("[TB] FAIL midreset_reach_byte got=%0d exp=6", byteCount); end
      rs = 1'b1;
      en = 1'b1;
      @(negedge clk);
      checks++; if (tm_stb !== 1'b1) begin errors++; $display("[TB] FAIL midreset_stb got=%b exp=1", tm_stb); end
      checks++; if (tm_clk !== 1'b1) begin errors++; $display("[TB] FAIL midreset_clk got=%b exp=1", tm_clk); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
      r = riseCount;
      clearMonitor();
      checks++; if (riseCount !== r) begin errors++; $display("[TB] FAIL midreset_clk_edges got=%0d exp=%0d", riseCount, r); end
      rs = 1'b0;
      @(negedge clk) en = 1'b0;
      c = 1;
      waitDone(c);
      checks++; if (c !== 627 || frame_done !== 1'b1) begin errors++; $display("[TB] FAIL midreset_latency got=%0d exp=627", c); end
      checks++; if (byteCount !== 19) begin errors++; $display("[TB] FAIL midreset_byte_count got=%0d exp=19", byteCount); end
      checks++; if (capBytes[0] !== 8'h40) begin errors++; $display("[TB] FAIL midreset_first_byte got=%h exp=40", capBytes[0]); end
      checks++; if (capBytes[1] !== 8'hC0) begin errors++; $display("[TB] FAIL midreset_addr_cmd got=%h exp=c0", capBytes[1]); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_digits();
      test_out_of_range();
      test_snapshot_refresh();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
